// File: rtl/router_dest_reader.sv
// router_dest_reader: drains one router port, framing header/payload/parity and checking parity
module router_dest_reader #(
  parameter int START_DLY = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  output logic       read_enb,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic [1:0] pkt_addr,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       abort,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DELAY, READ, DONE} state_t;
  state_t state, state_nxt;
  logic [4:0] dly;
  logic [6:0] issued, caps, total;
  logic [7:0] par;
  logic rd_q, perr, flush, start, last;
  assign start = state == IDLE && en && vld_out;
  assign flush = soft_reset && (state == DELAY || state == READ);
  assign total = caps == 7'd0 ? 7'd65 : {1'b0, pkt_len} + 7'd2;
  assign read_enb = state == READ && vld_out && issued < total;
  assign last = rd_q && caps != 7'd0 && caps == {1'b0, pkt_len} + 7'd1;
  assign busy = state != IDLE;
  assign pkt_done = state == DONE;
  assign parity_err = pkt_done && perr;
  // state register; reset overrides everything, including a pending flush
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // next state: soft_reset only aborts while a packet is being fetched
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = start ? DELAY : IDLE;
      DELAY:   state_nxt = soft_reset ? IDLE : dly == 5'd0 ? READ : DELAY;
      READ:    state_nxt = soft_reset ? IDLE : last ? DONE : READ;
      default: state_nxt = IDLE;
    endcase
  end
  // capture path: the byte read last cycle arrives now, first one is the header
  always_ff @(posedge clock) begin
    if (reset) begin
      dly <= '0;
      issued <= '0;
      caps <= '0;
      par <= '0;
      perr <= 1'b0;
      rd_q <= 1'b0;
      byte_valid <= 1'b0;
      byte_out <= '0;
      pkt_addr <= '0;
      pkt_len <= '0;
      abort <= 1'b0;
    end else begin
      abort <= flush;
      rd_q <= read_enb && !flush;
      byte_valid <= rd_q && !flush;
      if (state == IDLE || flush) begin
        dly <= 5'(START_DLY);
        issued <= '0;
        caps <= '0;
        par <= '0;
        perr <= 1'b0;
      end else begin
        if (state == DELAY && dly != 5'd0) dly <= dly - 5'd1;
        if (read_enb) issued <= issued + 7'd1;
        if (rd_q) begin
          byte_out <= data_out;
          caps <= caps + 7'd1;
          par <= par ^ data_out;
          if (caps == 7'd0) {pkt_len, pkt_addr} <= data_out;
          if (last) perr <= data_out != par;
        end
      end
    end
  end
endmodule

// File: tb/tb_router_dest_reader.sv
// tb_router_dest_reader: router-port model, packet scoreboard and directed corner cases
module tb_router_dest_reader;
  logic clock = 1'b0, reset = 1'b1, en = 1'b0, vld_out = 1'b0, soft_reset = 1'b0, gate = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic read_enb, byte_valid, pkt_done, parity_err, abort, busy;
  logic [7:0] byte_out;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic en5 = 1'b0, vld5 = 1'b0;
  logic read_enb5, byte_valid5, pkt_done5, parity_err5, abort5, busy5;
  logic [7:0] byte_out5;
  logic [1:0] pkt_addr5;
  logic [5:0] pkt_len5;
  typedef struct {logic [1:0] addr; logic [5:0] len; logic perr; logic ab; int nb;} pkt_t;
  logic [7:0] src[$], exp_bytes[$];
  pkt_t exp_pkt[$];
  pkt_t mon_e;
  int checks = 0, errors = 0, got = 0, reads = 0;

  router_dest_reader #(.START_DLY(0)) u0 (
    .clock(clock), .reset(reset), .en(en), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .read_enb(read_enb), .byte_valid(byte_valid), .byte_out(byte_out),
    .pkt_addr(pkt_addr), .pkt_len(pkt_len), .pkt_done(pkt_done), .parity_err(parity_err),
    .abort(abort), .busy(busy)
  );
  router_dest_reader #(.START_DLY(5)) u5 (
    .clock(clock), .reset(reset), .en(en5), .vld_out(vld5), .data_out(8'h00),
    .soft_reset(1'b0), .read_enb(read_enb5), .byte_valid(byte_valid5), .byte_out(byte_out5),
    .pkt_addr(pkt_addr5), .pkt_len(pkt_len5), .pkt_done(pkt_done5), .parity_err(parity_err5),
    .abort(abort5), .busy(busy5)
  );

  always #5 clock = ~clock;

  // router port: a read strobe presents the next queued byte in the following cycle
  always @(posedge clock) if (read_enb && src.size() != 0) data_out <= src.pop_front();
  always @(posedge clock) begin
    #2;
    vld_out = gate && src.size() != 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] par_of(input logic [7:0] h, input logic [7:0] pay[$]);
    logic [7:0] x = h;
    foreach (pay[i]) x ^= pay[i];
    return x;
  endfunction

  task automatic send(input logic [7:0] h, input logic [7:0] pay[$], input logic [7:0] pb, input bit ab);
    pkt_t e;
    src.push_back(h);
    exp_bytes.push_back(h);
    foreach (pay[i]) begin
      src.push_back(pay[i]);
      if (!ab || i == 0) exp_bytes.push_back(pay[i]);
    end
    src.push_back(pb);
    if (!ab) exp_bytes.push_back(pb);
    e.addr = h[1:0];
    e.len = h[7:2];
    e.perr = pb != par_of(h, pay);
    e.ab = ab;
    e.nb = ab ? 2 : pay.size() + 2;
    exp_pkt.push_back(e);
  endtask

  task automatic run(input bit rnd, input int lim);
    int n = 0;
    while (exp_pkt.size() != 0 && n < lim) begin
      @(posedge clock);
      #1;
      if (rnd) begin
        en = $urandom_range(0, 3) != 0;
        gate = $urandom_range(0, 3) != 0;
      end
      n++;
    end
    chk("drain_pending", exp_pkt.size(), 0);
    exp_pkt.delete();
    exp_bytes.delete();
    en = 1'b1;
    gate = 1'b1;
  endtask

  task automatic wait_bytes(input int cnt);
    int k = 0, n = 0;
    while (k < cnt && n < 300) begin
      @(posedge clock);
      #1;
      if (byte_valid) k++;
      n++;
    end
    chk("bytes_seen", k, cnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_read_enb"}, read_enb, 0);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_byte_out"}, byte_out, 0);
    chk({tag, "_pkt_addr"}, pkt_addr, 0);
    chk({tag, "_pkt_len"}, pkt_len, 0);
    chk({tag, "_pkt_done"}, pkt_done, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
    chk({tag, "_abort"}, abort, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_u5_state"}, {read_enb5, byte_valid5, byte_out5, pkt_addr5, pkt_len5, pkt_done5, parity_err5, abort5, busy5}, 0);
  endtask

  // scoreboard monitor: every captured byte and every packet end is matched against the queues
  always @(negedge clock) begin
    if (reset) begin
      got = 0;
      reads = 0;
    end else begin
      if (read_enb) reads++;
      if (!vld_out) chk("read_while_empty", read_enb, 0);
      if (!pkt_done) chk("parity_err_idle", parity_err, 0);
      if (byte_valid) begin
        got++;
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte got=%0h expected=none", byte_out);
        end else chk("byte_out", byte_out, exp_bytes.pop_front());
      end
      if (pkt_done || abort) begin
        if (exp_pkt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end done=%0b abort=%0b expected=none", pkt_done, abort);
        end else begin
          mon_e = exp_pkt.pop_front();
          chk("abort_vs_done", abort, mon_e.ab);
          chk("byte_count", got, mon_e.nb);
          if (mon_e.ab) chk("busy_after_abort", busy, 0);
          else begin
            chk("pkt_addr", pkt_addr, mon_e.addr);
            chk("pkt_len", pkt_len, mon_e.len);
            chk("parity_err", parity_err, mon_e.perr);
            chk("read_count", reads, mon_e.nb);
          end
        end
        got = 0;
        reads = 0;
      end
    end
  end

  initial begin
    logic [7:0] pay[$];
    logic [7:0] h, pb;
    int k;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;
    en5 = 1'b1;
    vld5 = 1'b1;
    @(posedge clock);
    #1;
    k = 0;
    while (!read_enb5 && k < 40) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("start_dly5", k, 6);
    vld5 = 1'b0;
    en = 1'b1;
    gate = 1'b1;
    pay = '{8'h11, 8'h22, 8'h33};
    send(8'h0E, pay, 8'h0E, 1'b0);
    @(posedge clock);
    #1;
    k = 0;
    while (!read_enb && k < 40) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("start_dly0", k, 1);
    run(1'b0, 200);
    send(8'h0E, pay, 8'h00, 1'b0);
    run(1'b0, 200);
    pay = '{8'hA5, 8'h5A};
    send(8'h09, pay, par_of(8'h09, pay), 1'b0);
    send(8'h00, '{}, 8'h00, 1'b0);
    k = 0;
    while (!pkt_done && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("b2b_done_seen", pkt_done, 1);
    @(posedge clock);
    #1;
    chk("b2b_idle", busy, 0);
    @(posedge clock);
    #1;
    chk("b2b_restart", busy, 1);
    run(1'b0, 200);
    pay = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    send(8'h17, pay, par_of(8'h17, pay), 1'b0);
    wait_bytes(3);
    gate = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    gate = 1'b1;
    run(1'b0, 200);
    soft_reset = 1'b1;
    @(posedge clock);
    #1;
    soft_reset = 1'b0;
    @(posedge clock);
    #1;
    chk("soft_reset_idle_abort", abort, 0);
    pay = '{8'hC3, 8'h3C, 8'h77, 8'h88};
    send(8'h12, pay, par_of(8'h12, pay), 1'b1);
    wait_bytes(2);
    soft_reset = 1'b1;
    @(posedge clock);
    #1;
    soft_reset = 1'b0;
    src.delete();
    run(1'b0, 50);
    for (int it = 0; it < 25; it++) begin
      for (int m = 0; m < int'($urandom_range(1, 2)); m++) begin
        pay.delete();
        repeat (it == 7 ? 63 : $urandom_range(0, 12)) pay.push_back(8'($urandom));
        h = {6'(pay.size()), 2'($urandom_range(0, 3))};
        pb = $urandom_range(0, 3) == 0 ? 8'($urandom) : par_of(h, pay);
        send(h, pay, pb, 1'b0);
      end
      run(1'b1, 3000);
    end
    pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    send(8'h1B, pay, par_of(8'h1B, pay), 1'b0);
    wait_bytes(2);
    reset = 1'b1;
    src.delete();
    exp_bytes.delete();
    exp_pkt.delete();
    @(posedge clock);
    #1;
    check_zero("mid_reset");
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_reset_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
